layer_task_sequencer: RTL and testbench

Program-driven scheduler for the accelerator's recv/send/conv task controller. Fetches 16-bit task descriptors from a descriptor BRAM and issues each as a one-cycle `task_valid` pulse with the matching enable pattern. It then waits for `ap_done` and repeats or advances until it reads an end marker. Sits between the host-side start register and the task controller, so one host start runs a whole layer sequence.

---
 rtl/layer_task_sequencer_pkg.sv | 44 ++++
 rtl/layer_task_sequencer_watchdog.sv | 38 +++
 rtl/layer_task_sequencer.sv | 167 ++++++++++++++++
 tb/tb_layer_task_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/layer_task_sequencer_pkg.sv
// layer_task_sequencer_pkg
// Shared definitions for the layer task sequencer: descriptor op encodings,
// descriptor field offsets, the sequencer state enum and error codes.
package layer_task_sequencer_pkg;

    // Op field is {recv, send, conv}
    localparam logic [2:0] OP_END       = 3'b000;
    localparam logic [2:0] OP_RECV      = 3'b100;
    localparam logic [2:0] OP_SEND      = 3'b010;
    localparam logic [2:0] OP_CONV      = 3'b001;
    localparam logic [2:0] OP_RECV_CONV = 3'b101;

    // Descriptor field layout
    localparam int OP_LSB   = 0;
    localparam int OP_W     = 3;
    localparam int REP_LSB  = 3;
    localparam int REP_W    = 10;
    localparam int RSVD_LSB = 13;

    localparam int OP_RECV_BIT = 2;
    localparam int OP_SEND_BIT = 1;
    localparam int OP_CONV_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_MASK,
        ST_WAIT,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_OP      = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op == OP_RECV) || (op == OP_SEND) ||
               (op == OP_CONV) || (op == OP_RECV_CONV);
    endfunction

endpackage

// File: rtl/layer_task_sequencer_watchdog.sv
// task_watchdog
// Saturating wait-cycle counter. Cleared by clr, advances while en is high.
// expired is asserted on the enabled cycle that completes 2^TIMEOUT_W-1
// counted cycles (and on any enabled cycle after that).
// Ports: clk, rst (sync, active-high), clr, en in; expired out.
module task_watchdog #(
    parameter int TIMEOUT_W = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [TIMEOUT_W-1:0] CNT_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = CNT_MAX - 1'b1;

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // cnt_q holds the wait cycles already elapsed; the current cycle is the
    // last one of the budget when cnt_q reaches CNT_LAST.
    assign expired = en && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/layer_task_sequencer.sv
// layer_task_sequencer
// Walks a descriptor program in BRAM and issues each op to the recv/send/conv
// task controller as a one-cycle task_valid pulse, repeating each op R+1
// times and waiting for ap_done between issues, until an end marker.
// Ports:
//   clk, rst (sync, active-high)
//   prog_start/prog_base in; prog_busy, prog_done, prog_error, err_code out
//   desc_rd_en/desc_rd_addr out, desc_rd_data in (1-cycle read latency)
//   task_valid, recv_enable, send_enable, conv_start out; ap_done in
//   task_count out: issues since last accepted start
module layer_task_sequencer
    import layer_task_sequencer_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DESC_W    = 16,
    parameter int TIMEOUT_W = 24,
    parameter int MASK_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_start,
    input  logic [ADDR_W-1:0] prog_base,
    output logic              prog_busy,
    output logic              prog_done,
    output logic              prog_error,
    output logic [1:0]        err_code,
    output logic              desc_rd_en,
    output logic [ADDR_W-1:0] desc_rd_addr,
    input  logic [DESC_W-1:0] desc_rd_data,
    output logic              task_valid,
    output logic              recv_enable,
    output logic              send_enable,
    output logic              conv_start,
    input  logic              ap_done,
    output logic [15:0]       task_count
);
    localparam int MSK_W = (MASK_CYC > 2) ? $clog2(MASK_CYC) : 1;
    localparam logic [MSK_W-1:0] MASK_LAST = (MASK_CYC > 0) ? MSK_W'(MASK_CYC - 1) : '0;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic [MSK_W-1:0]  mask_q, mask_d;
    logic [15:0]       task_count_q, task_count_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              wd_expired;
    logic [OP_W-1:0]   rd_op;
    logic [REP_W-1:0]  rd_rep;
    logic              unused_rsvd;

    assign rd_op       = desc_rd_data[OP_LSB +: OP_W];
    assign rd_rep      = desc_rd_data[REP_LSB +: REP_W];
    assign unused_rsvd = ^desc_rd_data[DESC_W-1:RSVD_LSB];

    // Watchdog restarts on every issue so each WAIT gets a full budget.
    task_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == ST_ISSUE),
        .en      (state_q == ST_WAIT),
        .expired (wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        op_d         = op_q;
        rep_d        = rep_q;
        mask_d       = mask_q;
        task_count_d = task_count_q;
        err_d        = err_q;
        err_code_d   = err_code_q;

        case (state_q)
            ST_IDLE: begin
                if (prog_start) begin
                    addr_d       = prog_base;
                    task_count_d = '0;
                    err_d        = 1'b0;
                    err_code_d   = ERR_NONE;
                    state_d      = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                op_d  = rd_op;
                rep_d = rd_rep;
                if (rd_op == OP_END) begin
                    state_d = ST_DONE;
                end else if (op_is_legal(rd_op)) begin
                    state_d = ST_ISSUE;
                end else begin
                    err_d      = 1'b1;
                    err_code_d = ERR_OP;
                    state_d    = ST_ERROR;
                end
            end
            ST_ISSUE: begin
                task_count_d = task_count_q + 16'd1;
                mask_d       = '0;
                state_d      = (MASK_CYC > 0) ? ST_MASK : ST_WAIT;
            end
            ST_MASK: begin
                // ap_done is ignored here: the controller's done flag from
                // the previous task may still be high.
                mask_d = mask_q + 1'b1;
                if (mask_q == MASK_LAST) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wd_expired) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_ERROR;
                end else if (ap_done) begin
                    if (rep_q != '0) begin
                        rep_d   = rep_q - 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            op_q         <= '0;
            rep_q        <= '0;
            mask_q       <= '0;
            task_count_q <= '0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            op_q         <= op_d;
            rep_q        <= rep_d;
            mask_q       <= mask_d;
            task_count_q <= task_count_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign task_valid   = (state_q == ST_ISSUE);
    assign recv_enable  = task_valid && op_q[OP_RECV_BIT];
    assign send_enable  = task_valid && op_q[OP_SEND_BIT];
    assign conv_start   = task_valid && op_q[OP_CONV_BIT];
    assign desc_rd_en   = (state_q == ST_FETCH);
    assign desc_rd_addr = addr_q;
    assign prog_busy    = (state_q != ST_IDLE);
    assign prog_done    = (state_q == ST_DONE);
    assign prog_error   = err_q;
    assign err_code     = err_code_q;
    assign task_count   = task_count_q;

endmodule

// File: tb/tb_layer_task_sequencer.sv
// Directed bench for layer_task_sequencer with a behavioural descriptor BRAM.
// Cycle numbers in comments count from the cycle prog_start is driven (c0).
module tb_layer_task_sequencer;
    localparam int ADDR_W = 10;
    localparam int DESC_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              prog_start;
    logic [ADDR_W-1:0] prog_base;
    logic              prog_busy, prog_done, prog_error;
    logic [1:0]        err_code;
    logic              desc_rd_en;
    logic [ADDR_W-1:0] desc_rd_addr;
    logic [DESC_W-1:0] desc_rd_data;
    logic              task_valid, recv_enable, send_enable, conv_start;
    logic              ap_done;
    logic [15:0]       task_count;

    logic [DESC_W-1:0] mem [0:(1<<ADDR_W)-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    layer_task_sequencer #(
        .ADDR_W(ADDR_W), .DESC_W(DESC_W), .TIMEOUT_W(4), .MASK_CYC(2)
    ) dut (
        .clk(clk), .rst(rst),
        .prog_start(prog_start), .prog_base(prog_base),
        .prog_busy(prog_busy), .prog_done(prog_done),
        .prog_error(prog_error), .err_code(err_code),
        .desc_rd_en(desc_rd_en), .desc_rd_addr(desc_rd_addr),
        .desc_rd_data(desc_rd_data),
        .task_valid(task_valid), .recv_enable(recv_enable),
        .send_enable(send_enable), .conv_start(conv_start),
        .ap_done(ap_done), .task_count(task_count)
    );

    always_ff @(posedge clk) begin
        if (desc_rd_en) desc_rd_data <= mem[desc_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives prog_start during c0 and returns in c1.
    task automatic start(input logic [ADDR_W-1:0] base);
        prog_start = 1'b1;
        prog_base  = base;
        tick();
        prog_start = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".task_valid"},  32'(task_valid),   32'd0);
        chk({tag, ".enables"},     32'({recv_enable, send_enable, conv_start}), 32'd0);
        chk({tag, ".desc_rd_en"},  32'(desc_rd_en),   32'd0);
        chk({tag, ".desc_rd_addr"},32'(desc_rd_addr), 32'd0);
        chk({tag, ".prog_busy"},   32'(prog_busy),    32'd0);
        chk({tag, ".prog_done"},   32'(prog_done),    32'd0);
        chk({tag, ".prog_error"},  32'(prog_error),   32'd0);
        chk({tag, ".err_code"},    32'(err_code),     32'd0);
        chk({tag, ".task_count"},  32'(task_count),   32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        prog_start = 1'b0;
        prog_base  = '0;
        ap_done    = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[0]    = 16'h0001;  // conv, R=0
        mem[1]    = 16'h0000;  // end
        mem[2]    = 16'h0003;  // illegal op 011
        mem[4]    = 16'h001C;  // recv, R=3
        mem[5]    = 16'h0000;
        mem[6]    = 16'h0002;  // send, R=0
        mem[7]    = 16'h0000;
        mem[8]    = 16'h0005;  // recv+conv, R=0
        mem[9]    = 16'h0000;
        mem[1023] = 16'hE002;  // send with reserved bits set

        // Reset state
        tick(2);
        chk_quiet("reset");
        rst = 1'b0;
        tick();

        // Single conv task
        start(10'd0);                                  // c1
        chk("single.rd_en_c1", 32'(desc_rd_en), 32'd1);
        chk("single.rd_addr_c1", 32'(desc_rd_addr), 32'd0);
        chk("single.busy_c1", 32'(prog_busy), 32'd1);
        tick();                                        // c2
        chk("single.tv_c2", 32'(task_valid), 32'd0);
        tick();                                        // c3
        chk("single.tv_c3", 32'(task_valid), 32'd1);
        chk("single.en_c3", 32'({recv_enable, send_enable, conv_start}), 32'b001);
        tick();                                        // c4
        chk("single.tv_c4", 32'(task_valid), 32'd0);
        chk("single.count_c4", 32'(task_count), 32'd1);
        tick(2);                                       // c6, WAIT
        ap_done = 1'b1;
        tick();                                        // c7
        ap_done = 1'b0;
        chk("single.rd_en_c7", 32'(desc_rd_en), 32'd1);
        chk("single.rd_addr_c7", 32'(desc_rd_addr), 32'd1);
        tick(2);                                       // c9
        chk("single.done_c9", 32'(prog_done), 32'd1);
        tick();                                        // c10
        chk("single.done_c10", 32'(prog_done), 32'd0);
        chk("single.busy_c10", 32'(prog_busy), 32'd0);
        chk("single.count_end", 32'(task_count), 32'd1);

        // Repeat with ap_done held high: four recv issues spaced 4 cycles
        ap_done = 1'b1;
        start(10'd4);
        for (int c = 1; c <= 22; c++) begin
            automatic logic exp_tv = (c == 3) || (c == 7) || (c == 11) || (c == 15);
            chk($sformatf("repeat.tv_c%0d", c), 32'(task_valid), 32'(exp_tv));
            chk($sformatf("repeat.recv_c%0d", c), 32'(recv_enable), 32'(exp_tv));
            chk($sformatf("repeat.done_c%0d", c), 32'(prog_done), 32'(c == 21));
            chk($sformatf("repeat.busy_c%0d", c), 32'(prog_busy), 32'(c <= 21));
            tick();
        end
        chk("repeat.count", 32'(task_count), 32'd4);
        ap_done = 1'b0;

        // Illegal op, sticky error, cleared by next start
        start(10'd2);                                  // c1
        tick(2);                                       // c3, ERROR
        chk("illegal.err_c3", 32'(prog_error), 32'd1);
        chk("illegal.code_c3", 32'(err_code), 32'b01);
        chk("illegal.busy_c3", 32'(prog_busy), 32'd1);
        chk("illegal.tv_c3", 32'(task_valid), 32'd0);
        tick();                                        // c4, IDLE
        chk("illegal.busy_c4", 32'(prog_busy), 32'd0);
        tick(3);
        chk("illegal.sticky_err", 32'(prog_error), 32'd1);
        chk("illegal.sticky_code", 32'(err_code), 32'b01);

        ap_done = 1'b1;
        start(10'd8);                                  // c1
        chk("restart.err_clr", 32'(prog_error), 32'd0);
        chk("restart.code_clr", 32'(err_code), 32'b00);
        prog_start = 1'b1;                             // must be ignored while busy
        prog_base  = 10'd2;
        tick();                                        // c2
        prog_start = 1'b0;
        tick();                                        // c3
        chk("restart.tv_c3", 32'(task_valid), 32'd1);
        chk("restart.en_c3", 32'({recv_enable, send_enable, conv_start}), 32'b101);
        tick(6);                                       // c9
        chk("restart.done_c9", 32'(prog_done), 32'd1);
        chk("restart.err_c9", 32'(prog_error), 32'd0);
        tick();
        ap_done = 1'b0;

        // Watchdog timeout: WAIT entered at c6, error visible at c21
        start(10'd6);                                  // c1
        tick(2);                                       // c3
        chk("timeout.send_c3", 32'(send_enable), 32'd1);
        tick(17);                                      // c20
        chk("timeout.err_c20", 32'(prog_error), 32'd0);
        chk("timeout.busy_c20", 32'(prog_busy), 32'd1);
        tick();                                        // c21
        chk("timeout.err_c21", 32'(prog_error), 32'd1);
        chk("timeout.code_c21", 32'(err_code), 32'b10);
        tick();                                        // c22
        chk("timeout.busy_c22", 32'(prog_busy), 32'd0);
        chk("timeout.code_c22", 32'(err_code), 32'b10);

        // Abort with rst during WAIT
        start(10'd6);                                  // c1
        tick(6);                                       // c7, WAIT
        chk("abort.busy_c7", 32'(prog_busy), 32'd1);
        rst = 1'b1;
        tick();
        chk_quiet("abort");
        rst = 1'b0;
        tick();
        chk("abort.busy_after", 32'(prog_busy), 32'd0);
        chk("abort.done_after", 32'(prog_done), 32'd0);

        // Address wrap from 1023 to 0
        ap_done = 1'b1;
        start(10'd1023);                               // c1
        chk("wrap.addr_c1", 32'(desc_rd_addr), 32'd1023);
        tick(2);                                       // c3
        chk("wrap.en_c3", 32'({recv_enable, send_enable, conv_start}), 32'b010);
        tick(4);                                       // c7
        chk("wrap.rd_en_c7", 32'(desc_rd_en), 32'd1);
        chk("wrap.addr_c7", 32'(desc_rd_addr), 32'd0);
        tick(2);                                       // c9
        chk("wrap.conv_c9", 32'(conv_start), 32'd1);
        tick(6);                                       // c15
        chk("wrap.done_c15", 32'(prog_done), 32'd1);
        tick();
        chk("wrap.count", 32'(task_count), 32'd2);
        ap_done = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
